// File: rtl/cordic_butterfly.sv
// Radix-2 FFT butterfly that pairs operand A with the rotated operand W*B
// returned by an upstream CORDIC rotator. A is delayed to meet its own
// rotated partner, then P = A + W*B and Q = A - W*B are either halved or
// saturated, registered, and tagged with an end-of-stage marker.
module cordic_butterfly #(
  parameter int DATA_WIDTH = 16,
  parameter int LATENCY    = 16,
  parameter int SCALE      = 1,
  parameter int HALF_N     = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] a_re,
  input  logic signed [DATA_WIDTH-1:0] a_im,
  input  logic signed [DATA_WIDTH-1:0] rot_re,
  input  logic signed [DATA_WIDTH-1:0] rot_im,
  input  logic                         clear_ovf,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] p_re,
  output logic signed [DATA_WIDTH-1:0] p_im,
  output logic signed [DATA_WIDTH-1:0] q_re,
  output logic signed [DATA_WIDTH-1:0] q_im,
  output logic                         out_last,
  output logic                         ovf
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = (HALF_N > 1) ? $clog2(HALF_N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_N - 1);
  localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic [LATENCY-1:0]  valid_pipe_reg;
  logic signed [W-1:0] a_re_pipe_reg [LATENCY];
  logic signed [W-1:0] a_im_pipe_reg [LATENCY];
  logic [CNT_W-1:0]    cnt_reg;
  logic                clamp_reg;

  logic                dv;
  logic signed [W-1:0] lane_a [4];
  logic signed [W-1:0] lane_r [4];
  logic [3:0][W-1:0]   lane_y;
  logic [3:0]          lane_clamp;

  // Valid bits travel alongside A; they are the only pipeline state that must clear on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_pipe_reg <= '0;
    end else begin
      valid_pipe_reg[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) begin
        valid_pipe_reg[i] <= valid_pipe_reg[i-1];
      end
    end
  end

  // A data delay line; contents are qualified by the valid bits so no reset is needed.
  always_ff @(posedge clock) begin
    a_re_pipe_reg[0] <= a_re;
    a_im_pipe_reg[0] <= a_im;
    for (int i = 1; i < LATENCY; i++) begin
      a_re_pipe_reg[i] <= a_re_pipe_reg[i-1];
      a_im_pipe_reg[i] <= a_im_pipe_reg[i-1];
    end
  end

  assign dv = valid_pipe_reg[LATENCY-1];

  // Lane order: 0 = p_re, 1 = p_im, 2 = q_re, 3 = q_im.
  assign lane_a[0] = a_re_pipe_reg[LATENCY-1];
  assign lane_a[1] = a_im_pipe_reg[LATENCY-1];
  assign lane_a[2] = a_re_pipe_reg[LATENCY-1];
  assign lane_a[3] = a_im_pipe_reg[LATENCY-1];
  assign lane_r[0] = rot_re;
  assign lane_r[1] = rot_im;
  assign lane_r[2] = rot_re;
  assign lane_r[3] = rot_im;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam bit IS_SUM = (gi < 2);
      logic [W:0]   a_ext;
      logic [W:0]   r_ext;
      logic [W:0]   sum;
      logic [W-1:0] y;
      logic         c;

      assign a_ext = {lane_a[gi][W-1], lane_a[gi]};
      assign r_ext = {lane_r[gi][W-1], lane_r[gi]};
      assign sum   = IS_SUM ? (a_ext + r_ext) : (a_ext - r_ext);

      // Halve by dropping the LSB (floor), or clamp when the two top bits disagree.
      always_comb begin
        y = sum[W:1];
        c = 1'b0;
        if (SCALE == 0) begin
          y = sum[W-1:0];
          if (sum[W] != sum[W-1]) begin
            c = 1'b1;
            y = sum[W] ? MIN_VAL : MAX_VAL;
          end
        end
      end

      assign lane_y[gi]     = y;
      assign lane_clamp[gi] = c;
    end
  endgenerate

  // Output register: results load only on a delayed-valid cycle and hold otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      clamp_reg <= 1'b0;
      cnt_reg   <= '0;
      p_re      <= '0;
      p_im      <= '0;
      q_re      <= '0;
      q_im      <= '0;
    end else begin
      out_valid <= dv;
      out_last  <= dv && (cnt_reg == CNT_MAX);
      clamp_reg <= dv && (|lane_clamp);
      if (dv) begin
        p_re    <= lane_y[0];
        p_im    <= lane_y[1];
        q_re    <= lane_y[2];
        q_im    <= lane_y[3];
        cnt_reg <= (cnt_reg == CNT_MAX) ? '0 : cnt_reg + 1'b1;
      end
    end
  end

  // Sticky overflow: raised the cycle after a clamped output; a new clamp beats a clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else begin
      ovf <= (ovf & ~clear_ovf) | clamp_reg;
    end
  end

endmodule

// File: tb/tb_cordic_butterfly.sv
// Bench for cordic_butterfly: one halving and one saturating instance share
// stimulus; a cycle-indexed expectation table plus plain-integer arithmetic
// predicts every output each cycle, and a few literal cases pin that model.
module tb_cordic_butterfly;

  localparam int W    = 16;
  localparam int L    = 16;
  localparam int HN   = 4;
  localparam int MAXC = 4096;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic clear_ovf = 1'b0;
  logic signed [W-1:0] a_re = '0, a_im = '0, rot_re = '0, rot_im = '0;

  // Index 0: SCALE=0 (saturate); index 1: SCALE=1 (halve).
  logic                out_valid_o [2];
  logic                out_last_o  [2];
  logic                ovf_o       [2];
  logic signed [W-1:0] p_re_o [2];
  logic signed [W-1:0] p_im_o [2];
  logic signed [W-1:0] q_re_o [2];
  logic signed [W-1:0] q_im_o [2];

  cordic_butterfly #(.DATA_WIDTH(W), .LATENCY(L), .SCALE(0), .HALF_N(HN)) u_sat (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .a_re(a_re), .a_im(a_im), .rot_re(rot_re), .rot_im(rot_im),
    .clear_ovf(clear_ovf), .out_valid(out_valid_o[0]),
    .p_re(p_re_o[0]), .p_im(p_im_o[0]), .q_re(q_re_o[0]), .q_im(q_im_o[0]),
    .out_last(out_last_o[0]), .ovf(ovf_o[0])
  );

  cordic_butterfly #(.DATA_WIDTH(W), .LATENCY(L), .SCALE(1), .HALF_N(HN)) u_half (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .a_re(a_re), .a_im(a_im), .rot_re(rot_re), .rot_im(rot_im),
    .clear_ovf(clear_ovf), .out_valid(out_valid_o[1]),
    .p_re(p_re_o[1]), .p_im(p_im_o[1]), .q_re(q_re_o[1]), .q_im(q_im_o[1]),
    .out_last(out_last_o[1]), .ovf(ovf_o[1])
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Expectation table indexed by the cycle a result must appear.
  bit ev    [MAXC];
  int ea_re [MAXC];
  int ea_im [MAXC];
  int er_re [MAXC];
  int er_im [MAXC];
  // Rotator schedule indexed by the cycle rot must be presented.
  bit rs_v  [MAXC];
  int rs_re [MAXC];
  int rs_im [MAXC];

  bit nx_valid = 0, nx_reset = 1, nx_clear = 0;
  int nx_a_re = 0, nx_a_im = 0, nx_r_re = 0, nx_r_im = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int fit(int s, int scale, output bit c);
    c = 1'b0;
    if (scale != 0) return s >>> 1;
    if (s > 32767) begin c = 1'b1; return 32767; end
    if (s < -32768) begin c = 1'b1; return -32768; end
    return s;
  endfunction

  function automatic int rnd16();
    logic signed [W-1:0] v;
    if ($urandom_range(0, 2) == 0) return int'($urandom_range(0, 400)) - 200;
    v = W'($urandom);
    return int'(v);
  endfunction

  // One clock: apply next-cycle intent, present the scheduled rotator output, record expectations.
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (cyc + L + 2 >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d got=%0d expected<%0d", cyc, cyc + L + 2, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    reset     = nx_reset;
    clear_ovf = nx_clear;
    in_valid  = nx_valid;
    a_re      = W'(nx_a_re);
    a_im      = W'(nx_a_im);
    if (rs_v[cyc]) begin
      rot_re = W'(rs_re[cyc]);
      rot_im = W'(rs_im[cyc]);
    end else begin
      rot_re = W'($urandom);
      rot_im = W'($urandom);
    end
    if (nx_reset) begin
      for (int k = cyc; k <= cyc + L + 1; k++) ev[k] = 1'b0;
    end else if (nx_valid) begin
      rs_v[cyc+L]    = 1'b1;
      rs_re[cyc+L]   = nx_r_re;
      rs_im[cyc+L]   = nx_r_im;
      ev[cyc+L+1]    = 1'b1;
      ea_re[cyc+L+1] = nx_a_re;
      ea_im[cyc+L+1] = nx_a_im;
      er_re[cyc+L+1] = nx_r_re;
      er_im[cyc+L+1] = nx_r_im;
    end
  endtask

  task automatic issue(int ar, int ai, int rr, int ri);
    nx_valid = 1'b1;
    nx_a_re = ar; nx_a_im = ai; nx_r_re = rr; nx_r_im = ri;
    tick();
    nx_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  // Reference model state per instance.
  int cnt_m [2];
  bit ovf_m [2];
  bit pclamp [2];
  bit pclear;
  int held [2][4];
  bit v_m, last_m, cl_m, c0, c1, c2, c3;
  int nv1 = 0, nl1 = 0;
  string pfx;

  // Per-cycle comparison of both instances against the model, away from the active edge.
  always @(negedge clock) begin
    for (int s = 0; s < 2; s++) begin
      pfx = (s == 0) ? "sat" : "half";
      v_m = 1'b0; last_m = 1'b0; cl_m = 1'b0;
      if (reset) begin
        for (int j = 0; j < 4; j++) held[s][j] = 0;
        cnt_m[s] = 0;
        ovf_m[s] = 1'b0;
      end else begin
        ovf_m[s] = (ovf_m[s] && !pclear) || pclamp[s];
        v_m = ev[cyc];
        if (v_m) begin
          held[s][0] = fit(ea_re[cyc] + er_re[cyc], s, c0);
          held[s][1] = fit(ea_im[cyc] + er_im[cyc], s, c1);
          held[s][2] = fit(ea_re[cyc] - er_re[cyc], s, c2);
          held[s][3] = fit(ea_im[cyc] - er_im[cyc], s, c3);
          cl_m = c0 | c1 | c2 | c3;
          last_m = (cnt_m[s] == HN - 1);
          cnt_m[s] = (cnt_m[s] + 1) % HN;
        end
      end
      pclamp[s] = cl_m;
      check({pfx, " out_valid"}, int'(out_valid_o[s]), int'(v_m));
      check({pfx, " out_last"}, int'(out_last_o[s]), int'(last_m));
      check({pfx, " ovf"}, int'(ovf_o[s]), int'(ovf_m[s]));
      check({pfx, " p_re"}, int'(p_re_o[s]), held[s][0]);
      check({pfx, " p_im"}, int'(p_im_o[s]), held[s][1]);
      check({pfx, " q_re"}, int'(q_re_o[s]), held[s][2]);
      check({pfx, " q_im"}, int'(q_im_o[s]), held[s][3]);
    end
    pclear = clear_ovf;
    if (out_valid_o[1]) nv1++;
    if (out_last_o[1]) nl1++;
    $display("cyc=%0d rst=%0d in_v=%0d sat:v=%0d l=%0d ovf=%0d half:v=%0d l=%0d p=(%0d,%0d) q=(%0d,%0d)",
             cyc, reset, in_valid, out_valid_o[0], out_last_o[0], ovf_o[0],
             out_valid_o[1], out_last_o[1], p_re_o[1], p_im_o[1], q_re_o[1], q_im_o[1]);
  end

  int base_v, base_l;

  initial begin
    nx_reset = 1'b1;
    idle(3);
    nx_reset = 1'b0;
    idle(2);

    // Halving reference case.
    issue(1000, -200, 300, 400);
    idle(L + 1);
    @(negedge clock);
    check("r029 out_valid", int'(out_valid_o[1]), 1);
    check("r029 p_re", int'(p_re_o[1]), 650);
    check("r029 p_im", int'(p_im_o[1]), 100);
    check("r029 q_re", int'(q_re_o[1]), 350);
    check("r029 q_im", int'(q_im_o[1]), -300);

    // Floor truncation on odd and negative-odd sums.
    issue(3, -3, 0, 0);
    idle(L + 1);
    @(negedge clock);
    check("r030 p_re", int'(p_re_o[1]), 1);
    check("r030 p_im", int'(p_im_o[1]), -2);
    check("r030 q_re", int'(q_re_o[1]), 1);
    check("r030 q_im", int'(q_im_o[1]), -2);
    idle(2);
    @(negedge clock);
    check("r030 ovf", int'(ovf_o[1]), 0);

    // Saturation in both directions, sticky flag, then clear.
    issue(30000, -30000, 10000, 10000);
    idle(L + 1);
    @(negedge clock);
    check("r031 p_re", int'(p_re_o[0]), 32767);
    check("r031 p_im", int'(p_im_o[0]), -20000);
    check("r031 q_re", int'(q_re_o[0]), 20000);
    check("r031 q_im", int'(q_im_o[0]), -32768);
    check("r031 ovf same cycle", int'(ovf_o[0]), 0);
    idle(1);
    @(negedge clock);
    check("r031 ovf next cycle", int'(ovf_o[0]), 1);
    idle(3);
    @(negedge clock);
    check("r031 ovf sticky", int'(ovf_o[0]), 1);
    nx_clear = 1'b1;
    tick();
    nx_clear = 1'b0;
    tick();
    @(negedge clock);
    check("r031 ovf cleared", int'(ovf_o[0]), 0);

    // Two stages with a three-cycle bubble in between.
    nx_reset = 1'b1;
    tick();
    nx_reset = 1'b0;
    tick();
    base_v = nv1;
    base_l = nl1;
    repeat (4) issue(rnd16(), rnd16(), rnd16(), rnd16());
    idle(3);
    repeat (4) issue(rnd16(), rnd16(), rnd16(), rnd16());
    idle(L + 4);
    check("r032 valid count", nv1 - base_v, 8);
    check("r032 last count", nl1 - base_l, 2);

    // Reset with five samples in flight.
    repeat (5) issue(rnd16(), rnd16(), rnd16(), rnd16());
    nx_reset = 1'b1;
    tick();
    nx_reset = 1'b0;
    @(negedge clock);
    check("r033 p_re zero", int'(p_re_o[1]), 0);
    check("r033 q_im zero", int'(q_im_o[0]), 0);
    base_v = nv1;
    idle(L + 2);
    check("r033 no output", nv1 - base_v, 0);

    // Random streams with bubbles, clears and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      nx_valid = ($urandom_range(0, 9) < 7);
      nx_clear = ($urandom_range(0, 15) == 0);
      nx_reset = ($urandom_range(0, 399) == 0);
      nx_a_re = rnd16(); nx_a_im = rnd16();
      nx_r_re = rnd16(); nx_r_im = rnd16();
      tick();
    end
    nx_valid = 1'b0;
    nx_clear = 1'b0;
    nx_reset = 1'b0;
    idle(L + 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
